// File: rtl/icm_page_table.sv
// ICM-to-physical page table: a single-port translation array with a flop valid
// vector. Lookups, maps and unmaps are serialized through a small FSM.
module icm_page_table #(
  parameter int unsigned ICM_ENTRY_NUM        = 256,
  parameter int unsigned ICM_ENTRY_NUM_LOG    = 8,
  parameter int unsigned ICM_SPACE_ADDR_WIDTH = 64,
  parameter int unsigned PHY_SPACE_ADDR_WIDTH = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            lookup_valid,
  input  logic [ICM_ENTRY_NUM_LOG-1:0]    lookup_head,
  output logic                            lookup_busy,
  output logic                            rsp_valid,
  output logic [ICM_SPACE_ADDR_WIDTH-1:0] rsp_icm_addr,
  output logic [PHY_SPACE_ADDR_WIDTH-1:0] rsp_phy_addr,
  output logic                            rsp_miss,
  input  logic                            map_valid,
  output logic                            map_ready,
  input  logic [ICM_ENTRY_NUM_LOG-1:0]    map_index,
  input  logic [ICM_SPACE_ADDR_WIDTH-1:0] map_icm_addr,
  input  logic [PHY_SPACE_ADDR_WIDTH-1:0] map_phy_addr,
  input  logic                            unmap_valid,
  output logic                            unmap_ready,
  input  logic [ICM_ENTRY_NUM_LOG-1:0]    unmap_index,
  output logic [ICM_ENTRY_NUM_LOG:0]      valid_entry_cnt
);

  localparam int unsigned CNT_W = ICM_ENTRY_NUM_LOG + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ICM_ENTRY_NUM);

  typedef enum logic [2:0] {
    IDLE,
    LKP_RD,
    LKP_RSP,
    MAP_WR,
    UNMAP_WR
  } state_e;

  state_e state_q, state_d;

  logic [ICM_ENTRY_NUM-1:0]        valid_q, valid_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;

  logic [ICM_SPACE_ADDR_WIDTH-1:0] icm_mem [ICM_ENTRY_NUM];
  logic [PHY_SPACE_ADDR_WIDTH-1:0] phy_mem [ICM_ENTRY_NUM];

  logic [ICM_ENTRY_NUM_LOG-1:0]    head_q;
  logic [ICM_ENTRY_NUM_LOG-1:0]    map_idx_q;
  logic [ICM_SPACE_ADDR_WIDTH-1:0] map_icm_q;
  logic [PHY_SPACE_ADDR_WIDTH-1:0] map_phy_q;
  logic [ICM_ENTRY_NUM_LOG-1:0]    unmap_idx_q;

  logic [ICM_SPACE_ADDR_WIDTH-1:0] rd_icm_q;
  logic [PHY_SPACE_ADDR_WIDTH-1:0] rd_phy_q;
  logic                            rd_hit_q;

  logic map_in_range, unmap_in_range, head_in_range;
  logic map_set, unmap_clr, lkp_hit;

  function automatic logic in_range(input logic [ICM_ENTRY_NUM_LOG-1:0] idx);
    return 32'(idx) < ICM_ENTRY_NUM;
  endfunction

  assign map_in_range   = in_range(map_idx_q);
  assign unmap_in_range = in_range(unmap_idx_q);
  assign head_in_range  = in_range(head_q);

  assign map_set   = (state_q == MAP_WR)   && map_in_range   && !valid_q[map_idx_q];
  assign unmap_clr = (state_q == UNMAP_WR) && unmap_in_range &&  valid_q[unmap_idx_q];
  assign lkp_hit   = head_in_range && valid_q[head_q];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (lookup_valid)     state_d = LKP_RD;
        else if (unmap_valid) state_d = UNMAP_WR;
        else if (map_valid)   state_d = MAP_WR;
      end
      LKP_RD:   state_d = LKP_RSP;
      LKP_RSP:  state_d = IDLE;
      MAP_WR:   state_d = IDLE;
      UNMAP_WR: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Remap of a valid entry and unmap of an invalid one leave the count alone.
  always_comb begin
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (map_set) begin
      valid_d[map_idx_q] = 1'b1;
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
    end
    if (unmap_clr) begin
      valid_d[unmap_idx_q] = 1'b0;
      if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request fields are captured every IDLE cycle; the copy taken on the
  // departing edge is the one the following state acts on.
  always_ff @(posedge clk) begin
    if (state_q == IDLE) begin
      head_q      <= lookup_head;
      map_idx_q   <= map_index;
      map_icm_q   <= map_icm_addr;
      map_phy_q   <= map_phy_addr;
      unmap_idx_q <= unmap_index;
    end
    if (state_q == MAP_WR && map_in_range) begin
      icm_mem[map_idx_q] <= map_icm_q;
      phy_mem[map_idx_q] <= map_phy_q;
    end
    if (state_q == LKP_RD) begin
      rd_icm_q <= icm_mem[head_q];
      rd_phy_q <= phy_mem[head_q];
      rd_hit_q <= lkp_hit;
    end
  end

  assign lookup_busy     = (state_q != IDLE);
  assign rsp_valid       = (state_q == LKP_RSP);
  assign rsp_miss        = rsp_valid && !rd_hit_q;
  assign rsp_icm_addr    = (rsp_valid && rd_hit_q) ? rd_icm_q : '0;
  assign rsp_phy_addr    = (rsp_valid && rd_hit_q) ? rd_phy_q : '0;
  assign map_ready       = (state_q == MAP_WR);
  assign unmap_ready     = (state_q == UNMAP_WR);
  assign valid_entry_cnt = cnt_q;

endmodule

// File: tb/tb_icm_page_table.sv
// Directed bench for icm_page_table, sized with 200 entries so that indices
// 200..255 exercise the out-of-range path.
module tb_icm_page_table;

  localparam int unsigned NUM = 200;
  localparam int unsigned LOG = 8;
  localparam int unsigned AW  = 64;

  logic           clk;
  logic           rst;
  logic           lookup_valid;
  logic [LOG-1:0] lookup_head;
  logic           lookup_busy;
  logic           rsp_valid;
  logic [AW-1:0]  rsp_icm_addr;
  logic [AW-1:0]  rsp_phy_addr;
  logic           rsp_miss;
  logic           map_valid;
  logic           map_ready;
  logic [LOG-1:0] map_index;
  logic [AW-1:0]  map_icm_addr;
  logic [AW-1:0]  map_phy_addr;
  logic           unmap_valid;
  logic           unmap_ready;
  logic [LOG-1:0] unmap_index;
  logic [LOG:0]   valid_entry_cnt;

  int unsigned err_cnt = 0;
  int unsigned chk_cnt = 0;

  icm_page_table #(
    .ICM_ENTRY_NUM       (NUM),
    .ICM_ENTRY_NUM_LOG   (LOG),
    .ICM_SPACE_ADDR_WIDTH(AW),
    .PHY_SPACE_ADDR_WIDTH(AW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .lookup_valid   (lookup_valid),
    .lookup_head    (lookup_head),
    .lookup_busy    (lookup_busy),
    .rsp_valid      (rsp_valid),
    .rsp_icm_addr   (rsp_icm_addr),
    .rsp_phy_addr   (rsp_phy_addr),
    .rsp_miss       (rsp_miss),
    .map_valid      (map_valid),
    .map_ready      (map_ready),
    .map_index      (map_index),
    .map_icm_addr   (map_icm_addr),
    .map_phy_addr   (map_phy_addr),
    .unmap_valid    (unmap_valid),
    .unmap_ready    (unmap_ready),
    .unmap_index    (unmap_index),
    .valid_entry_cnt(valid_entry_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_map(input string tag, input logic [LOG-1:0] idx,
                        input logic [AW-1:0] icm, input logic [AW-1:0] phy,
                        input logic [LOG:0] exp_cnt);
    int unsigned n = 0;
    map_valid    = 1'b1;
    map_index    = idx;
    map_icm_addr = icm;
    map_phy_addr = phy;
    do begin
      @(negedge clk);
      n++;
    end while (!map_ready && n < 8);
    check_eq({tag, ".ready"}, 64'(map_ready), 64'd1);
    check_eq({tag, ".lat"}, 64'(n), 64'd1);
    map_valid = 1'b0;
    @(negedge clk);
    check_eq({tag, ".ready_low"}, 64'(map_ready), 64'd0);
    check_eq({tag, ".cnt"}, 64'(valid_entry_cnt), 64'(exp_cnt));
  endtask

  task automatic do_unmap(input string tag, input logic [LOG-1:0] idx,
                          input logic [LOG:0] exp_cnt);
    int unsigned n = 0;
    unmap_valid = 1'b1;
    unmap_index = idx;
    do begin
      @(negedge clk);
      n++;
    end while (!unmap_ready && n < 8);
    check_eq({tag, ".ready"}, 64'(unmap_ready), 64'd1);
    check_eq({tag, ".lat"}, 64'(n), 64'd1);
    unmap_valid = 1'b0;
    @(negedge clk);
    check_eq({tag, ".ready_low"}, 64'(unmap_ready), 64'd0);
    check_eq({tag, ".cnt"}, 64'(valid_entry_cnt), 64'(exp_cnt));
  endtask

  task automatic do_lookup(input string tag, input logic [LOG-1:0] idx, input logic exp_miss,
                           input logic [AW-1:0] exp_icm, input logic [AW-1:0] exp_phy);
    lookup_valid = 1'b1;
    lookup_head  = idx;
    @(negedge clk);
    lookup_valid = 1'b0;
    check_eq({tag, ".busy"}, 64'(lookup_busy), 64'd1);
    check_eq({tag, ".rsp_early"}, 64'(rsp_valid), 64'd0);
    @(negedge clk);
    check_eq({tag, ".rsp_valid"}, 64'(rsp_valid), 64'd1);
    check_eq({tag, ".miss"}, 64'(rsp_miss), 64'(exp_miss));
    check_eq({tag, ".icm"}, rsp_icm_addr, exp_icm);
    check_eq({tag, ".phy"}, rsp_phy_addr, exp_phy);
    @(negedge clk);
    check_eq({tag, ".rsp_end"}, 64'(rsp_valid), 64'd0);
    check_eq({tag, ".icm_idle"}, rsp_icm_addr, 64'd0);
    check_eq({tag, ".busy_end"}, 64'(lookup_busy), 64'd0);
  endtask

  initial begin
    int rsp_at, un_at, mp_at, rsp_n;
    logic [NUM-1:0] mdl_valid;
    int unsigned cnt_m;

    rst = 1'b1;
    lookup_valid = 1'b0; lookup_head = '0;
    map_valid = 1'b0; map_index = '0; map_icm_addr = '0; map_phy_addr = '0;
    unmap_valid = 1'b0; unmap_index = '0;
    repeat (3) @(negedge clk);
    check_eq("rst.busy", 64'(lookup_busy), 64'd0);
    check_eq("rst.rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("rst.map_ready", 64'(map_ready), 64'd0);
    check_eq("rst.unmap_ready", 64'(unmap_ready), 64'd0);
    check_eq("rst.cnt", 64'(valid_entry_cnt), 64'd0);
    check_eq("rst.icm", rsp_icm_addr, 64'd0);
    check_eq("rst.miss", 64'(rsp_miss), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic map and hit / miss lookups
    do_map("map5", 8'd5, 64'h1000, 64'hABC000, 9'd1);
    do_lookup("lkp5", 8'd5, 1'b0, 64'h1000, 64'hABC000);
    do_lookup("lkp7", 8'd7, 1'b1, 64'h0, 64'h0);

    // Remap and double unmap
    do_map("remap5", 8'd5, 64'h1000, 64'hABC000, 9'd1);
    do_unmap("unmap5a", 8'd5, 9'd0);
    do_unmap("unmap5b", 8'd5, 9'd0);
    do_lookup("lkp5_gone", 8'd5, 1'b1, 64'h0, 64'h0);

    // Last in-range index and out-of-range index
    do_map("map199", 8'd199, 64'hC7000, 64'h1990000, 9'd1);
    do_lookup("lkp199", 8'd199, 1'b0, 64'hC7000, 64'h1990000);
    do_map("map250", 8'd250, 64'hFA000, 64'hFA0000, 9'd1);
    do_lookup("lkp250", 8'd250, 1'b1, 64'h0, 64'h0);
    do_unmap("unmap250", 8'd250, 9'd1);

    // Simultaneous lookup/unmap/map: lookup sees entry 3 before it is unmapped
    do_map("map3", 8'd3, 64'h3000, 64'h33000, 9'd2);
    rsp_at = -1; un_at = -1; mp_at = -1;
    lookup_valid = 1'b1; lookup_head = 8'd3;
    unmap_valid  = 1'b1; unmap_index = 8'd3;
    map_valid    = 1'b1; map_index = 8'd9; map_icm_addr = 64'h2000; map_phy_addr = 64'h9000;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) lookup_valid = 1'b0;
      if (rsp_valid && rsp_at < 0) begin
        rsp_at = c;
        check_eq("mix.miss", 64'(rsp_miss), 64'd0);
        check_eq("mix.icm", rsp_icm_addr, 64'h3000);
        check_eq("mix.phy", rsp_phy_addr, 64'h33000);
      end
      if (unmap_ready && un_at < 0) begin
        un_at = c;
        unmap_valid = 1'b0;
      end
      if (map_ready && mp_at < 0) begin
        mp_at = c;
        map_valid = 1'b0;
      end
    end
    check_eq("mix.rsp_at", 64'(rsp_at), 64'd2);
    check_eq("mix.unmap_at", 64'(un_at), 64'd4);
    check_eq("mix.map_at", 64'(mp_at), 64'd6);
    check_eq("mix.cnt", 64'(valid_entry_cnt), 64'd2);
    do_lookup("lkp3_gone", 8'd3, 1'b1, 64'h0, 64'h0);
    do_lookup("lkp9", 8'd9, 1'b0, 64'h2000, 64'h9000);

    // Second lookup while busy is dropped
    rsp_n = 0;
    lookup_valid = 1'b1; lookup_head = 8'd9;
    @(negedge clk);
    check_eq("drop.busy", 64'(lookup_busy), 64'd1);
    lookup_head = 8'd3;
    for (int c = 2; c <= 6; c++) begin
      @(negedge clk);
      lookup_valid = 1'b0;
      if (rsp_valid) begin
        rsp_n++;
        check_eq("drop.icm", rsp_icm_addr, 64'h2000);
        check_eq("drop.miss", 64'(rsp_miss), 64'd0);
      end
    end
    check_eq("drop.rsp_count", 64'(rsp_n), 64'd1);

    // Fill every entry; count must reach the table size
    mdl_valid = '0;
    mdl_valid[9] = 1'b1;
    mdl_valid[199] = 1'b1;
    cnt_m = 2;
    for (int unsigned i = 0; i < NUM; i++) begin
      if (!mdl_valid[i]) cnt_m++;
      mdl_valid[i] = 1'b1;
      do_map("fill", LOG'(i), 64'(i) << 12, 64'(i) << 20, (LOG+1)'(cnt_m));
    end
    check_eq("fill.cnt", 64'(valid_entry_cnt), 64'd200);
    do_lookup("lkp150", 8'd150, 1'b0, 64'h96000, 64'h9600000);

    // Reset while a lookup is in flight
    lookup_valid = 1'b1; lookup_head = 8'd9;
    @(negedge clk);
    lookup_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rstlk.rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("rstlk.busy", 64'(lookup_busy), 64'd0);
    check_eq("rstlk.cnt", 64'(valid_entry_cnt), 64'd0);
    rsp_n = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (rsp_valid) rsp_n++;
    end
    check_eq("rstlk.no_rsp", 64'(rsp_n), 64'd0);
    do_lookup("rst_lkp9", 8'd9, 1'b1, 64'h0, 64'h0);
    do_lookup("rst_lkp150", 8'd150, 1'b1, 64'h0, 64'h0);
    do_lookup("rst_lkp199", 8'd199, 1'b1, 64'h0, 64'h0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
